// File: rtl/irq_ctrl_if.sv
// Peripheral-bus and CPU-handshake bundle for irq_ctrl.
// The CPU/bus side uses the master modport; the controller uses the slave modport.
interface irq_ctrl_if #(
  parameter int NSRC = 4
);
  logic [NSRC-1:0] src_irq;
  logic            kernel_mode;
  logic            irq_take;
  logic            mem_rd;
  logic            mem_wr;
  logic [31:0]     addr;
  logic [31:0]     wdata;
  logic            irq;
  logic [31:0]     rdata;

  modport master (
    output src_irq, kernel_mode, irq_take, mem_rd, mem_wr, addr, wdata,
    input  irq, rdata
  );

  modport slave (
    input  src_irq, kernel_mode, irq_take, mem_rd, mem_wr, addr, wdata,
    output irq, rdata
  );
endinterface

// File: rtl/irq_ctrl.sv
// Interrupt controller: pending/enable registers, fixed priority, take/service/return FSM.
// Optional IRQ_CTRL_EDGE_EN makes sources rising-edge triggered instead of level.
module irq_ctrl #(
  parameter int          NSRC = 4,
  parameter logic [31:0] BASE = 32'h40000030
) (
  input  logic       clk,
  input  logic       reset,
  irq_ctrl_if.slave  bus
);
  // state    | meaning
  // IDLE     | no request outstanding
  // ASSERT   | irq high, waiting for the CPU to take the vector
  // SERVICE  | handler running; wait for kernel_mode 1 -> 0
  typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_SERVICE} state_t;

  state_t          r_state;
  logic [NSRC-1:0] r_ie;
  logic [NSRC-1:0] r_ip;
  logic [2:0]      r_ivec;
  logic            r_gie;
  logic            r_irq;
  logic            r_kseen;

  logic [NSRC-1:0] w_set;
  logic [NSRC-1:0] w_clr;
  logic [NSRC-1:0] w_act;
  logic            w_any_act;
  logic [2:0]      w_pri_id;
  logic            w_sel_ie, w_sel_ip, w_sel_ivec, w_sel_ctrl;
  logic [31:0]     w_rdata;
  logic            w_unused;

  assign w_sel_ie   = (bus.addr == BASE);
  assign w_sel_ip   = (bus.addr == BASE + 32'd4);
  assign w_sel_ivec = (bus.addr == BASE + 32'd8);
  assign w_sel_ctrl = (bus.addr == BASE + 32'd12);
  assign w_unused   = ^bus.wdata[31:NSRC];

`ifdef IRQ_CTRL_EDGE_EN
  logic [NSRC-1:0] r_src_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_src_q <= '0;
    else        r_src_q <= bus.src_irq;
  end

  assign w_set = bus.src_irq & ~r_src_q;
`else
  assign w_set = bus.src_irq;
`endif

  assign w_clr     = (bus.mem_wr && w_sel_ip) ? bus.wdata[NSRC-1:0] : '0;
  assign w_act     = r_ip & r_ie;
  assign w_any_act = |w_act;

  // Scan downward so the lowest active index is the last assignment.
  always_comb begin
    w_pri_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_act[i]) w_pri_id = 3'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ie  <= '0;
      r_ip  <= '0;
      r_gie <= 1'b0;
    end else begin
      r_ip <= (r_ip & ~w_clr) | w_set;
      if (bus.mem_wr && w_sel_ie)   r_ie  <= bus.wdata[NSRC-1:0];
      if (bus.mem_wr && w_sel_ctrl) r_gie <= bus.wdata[0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_irq   <= 1'b0;
      r_ivec  <= '0;
      r_kseen <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_gie && w_any_act && !bus.kernel_mode) begin
            r_state <= S_ASSERT;
            r_irq   <= 1'b1;
          end
        end
        S_ASSERT: begin
          if (bus.irq_take) begin
            r_ivec  <= w_pri_id;
            r_state <= S_SERVICE;
            r_irq   <= 1'b0;
            r_kseen <= 1'b0;
          end else if (!w_any_act || !r_gie || bus.kernel_mode) begin
            r_state <= S_IDLE;
            r_irq   <= 1'b0;
          end
        end
        S_SERVICE: begin
          r_irq <= 1'b0;
          if (bus.kernel_mode) begin
            r_kseen <= 1'b1;
          end else if (r_kseen) begin
            r_state <= S_IDLE;
            r_kseen <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_irq   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_rdata = '0;
    if (bus.mem_rd) begin
      if (w_sel_ie)   w_rdata[NSRC-1:0] = r_ie;
      if (w_sel_ip)   w_rdata[NSRC-1:0] = r_ip;
      if (w_sel_ivec) w_rdata[2:0]      = r_ivec;
      if (w_sel_ctrl) w_rdata[1:0]      = {(r_state == S_SERVICE), r_gie};
    end
  end

  assign bus.rdata = w_rdata;
  assign bus.irq   = r_irq;
endmodule
